// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Round-robin arbiter that shares one APB master between NREQ requesters.
//   The arbiter grants one request, latches its fields into m_*, and pulses
//   m_transfer for one cycle. It then watches PENABLE/PREADY on the bus and
//   returns PRDATA/PSLVERR to the winner with a one-cycle rsp_valid pulse.
//   Only one transfer is outstanding at a time.
//
//   Optional feature: define APB_ARB_TIMEOUT_EN to enable a wait-cycle
//   timeout. After TIMEOUT cycles in WAIT without completion, the arbiter
//   returns an error response. It then drains the late bus completion
//   silently.
//
// Ports
//   PCLK, PRESETn                  clock, async active-low reset
//   req_valid/addr/wdata/write/    flattened per-requester request fields
//   strb/prot                      (requester i at slice [i*W +: W])
//   req_ready                      one-hot accept pulse (combinational, IDLE only)
//   rsp_valid, rsp_rdata, rsp_err  one-hot completion pulse + response data
//   m_addr/wdata/write/strb/prot   registered transfer fields to the APB master
//   m_transfer                     registered one-cycle transfer request
//   PENABLE, PREADY, PSLVERR,      APB bus monitor inputs
//   PRDATA
module apb_req_arbiter #(
  parameter int unsigned ADDRSIZE = 32,
  parameter int unsigned DATASIZE = 32,
  parameter int unsigned NREQ     = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDRSIZE-1:0]   req_addr,
  input  logic [NREQ*DATASIZE-1:0]   req_wdata,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*DATASIZE/8-1:0] req_strb,
  input  logic [NREQ*3-1:0]          req_prot,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATASIZE-1:0]        rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDRSIZE-1:0]        m_addr,
  output logic [DATASIZE-1:0]        m_wdata,
  output logic                       m_write,
  output logic [DATASIZE/8-1:0]      m_strb,
  output logic [2:0]                 m_prot,
  output logic                       m_transfer,
  input  logic                       PENABLE,
  input  logic                       PREADY,
  input  logic                       PSLVERR,
  input  logic [DATASIZE-1:0]        PRDATA
);

  localparam int unsigned StrbW = DATASIZE / 8;
  localparam int unsigned GntW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

`ifdef APB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  state_e          state_q;
  logic [GntW-1:0] last_grant_q;
  logic            grant_found;
  logic [GntW-1:0] grant_idx;
  logic [GntW-1:0] cand;
  logic            bus_done;

  // Unpacked views of the flattened request buses.
  logic [ADDRSIZE-1:0] addr_arr  [NREQ];
  logic [DATASIZE-1:0] wdata_arr [NREQ];
  logic [StrbW-1:0]    strb_arr  [NREQ];
  logic [2:0]          prot_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDRSIZE +: ADDRSIZE];
    assign wdata_arr[g] = req_wdata[g*DATASIZE +: DATASIZE];
    assign strb_arr[g]  = req_strb[g*StrbW +: StrbW];
    assign prot_arr[g]  = req_prot[g*3 +: 3];
  end

  assign bus_done = PENABLE && PREADY;

  // Search starts one past the last winner and wraps, so every requester
  // gets a turn under continuous contention.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = GntW'((32'(last_grant_q) + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Gated with PRESETn so every output reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (PRESETn && (state_q == StIdle) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= StIdle;
      last_grant_q <= GntW'(NREQ - 1);
      m_addr       <= '0;
      m_wdata      <= '0;
      m_write      <= 1'b0;
      m_strb       <= '0;
      m_prot       <= '0;
      m_transfer   <= 1'b0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            m_addr       <= addr_arr[grant_idx];
            m_wdata      <= wdata_arr[grant_idx];
            m_write      <= req_write[grant_idx];
            m_strb       <= strb_arr[grant_idx];
            m_prot       <= prot_arr[grant_idx];
            m_transfer   <= 1'b1;
            last_grant_q <= grant_idx;
            state_q      <= StReq;
          end
        end
        StReq: begin
          m_transfer <= 1'b0;
          state_q    <= StWait;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_q      <= '0;
`endif
        end
        StWait: begin
          if (bus_done) begin
            rsp_rdata <= m_write ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            rsp_valid <= OneHot0 << last_grant_q;
            state_q   <= StIdle;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= OneHot0 << last_grant_q;
            state_q   <= StDrain;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
`ifdef APB_ARB_TIMEOUT_EN
        // The requester already has its error response; swallow the late
        // completion so the bus is free before the next grant.
        StDrain: begin
          if (bus_done) begin
            state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;

  // NREQ=2 instance
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_write;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_write;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  logic        m_transfer;
  logic        PENABLE, PREADY, PSLVERR;
  logic [31:0] PRDATA;

  // NREQ=4 instance
  logic [3:0]   req_valid4;
  logic [127:0] req_addr4;
  logic [127:0] req_wdata4;
  logic [3:0]   req_write4;
  logic [15:0]  req_strb4;
  logic [11:0]  req_prot4;
  logic [3:0]   req_ready4;
  logic [3:0]   rsp_valid4;
  logic [31:0]  rsp_rdata4;
  logic         rsp_err4;
  logic [31:0]  m_addr4;
  logic [31:0]  m_wdata4;
  logic         m_write4;
  logic [3:0]   m_strb4;
  logic [2:0]   m_prot4;
  logic         m_transfer4;
  logic         PENABLE4, PREADY4, PSLVERR4;
  logic [31:0]  PRDATA4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter #(.ADDRSIZE(32), .DATASIZE(32), .NREQ(2), .TIMEOUT(8)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_strb(req_strb), .req_prot(req_prot),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write),
    .m_strb(m_strb), .m_prot(m_prot), .m_transfer(m_transfer),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  apb_req_arbiter #(.ADDRSIZE(32), .DATASIZE(32), .NREQ(4), .TIMEOUT(8)) u_dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid4), .req_addr(req_addr4), .req_wdata(req_wdata4),
    .req_write(req_write4), .req_strb(req_strb4), .req_prot(req_prot4),
    .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
    .rsp_err(rsp_err4), .m_addr(m_addr4), .m_wdata(m_wdata4), .m_write(m_write4),
    .m_strb(m_strb4), .m_prot(m_prot4), .m_transfer(m_transfer4),
    .PENABLE(PENABLE4), .PREADY(PREADY4), .PSLVERR(PSLVERR4), .PRDATA(PRDATA4)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  strb0, strb1;
    logic [2:0]  prot0, prot1;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    int          win;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic [2:0]  e_prot;
    logic        e_write;
    e_addr  = (v.win == 0) ? v.addr0  : v.addr1;
    e_wdata = (v.win == 0) ? v.wdata0 : v.wdata1;
    e_strb  = (v.win == 0) ? v.strb0  : v.strb1;
    e_prot  = (v.win == 0) ? v.prot0  : v.prot1;
    e_write = v.write[v.win];
    // Cycle t: request presented in IDLE
    req_valid = v.valid;
    req_write = v.write;
    req_addr  = {v.addr1, v.addr0};
    req_wdata = {v.wdata1, v.wdata0};
    req_strb  = {v.strb1, v.strb0};
    req_prot  = {v.prot1, v.prot0};
    @(negedge PCLK);
    chk($sformatf("v%0d req_ready", idx), 64'(req_ready), 64'(2'b01 << v.win));
    tick();
    // t+1: transfer request with latched fields
    req_valid = 2'b00;
    @(negedge PCLK);
    chk($sformatf("v%0d m_transfer hi", idx), 64'(m_transfer), 64'(1));
    chk($sformatf("v%0d m_addr", idx), 64'(m_addr), 64'(e_addr));
    chk($sformatf("v%0d m_wdata", idx), 64'(m_wdata), 64'(e_wdata));
    chk($sformatf("v%0d m_prot", idx), 64'(m_prot), 64'(e_prot));
    tick();
    // t+2: master in setup
    @(negedge PCLK);
    chk($sformatf("v%0d m_transfer lo", idx), 64'(m_transfer), 64'(0));
    tick();
    // Access phase with v.waits wait states
    for (int w = 0; w <= v.waits; w++) begin
      PENABLE = 1'b1;
      PREADY  = (w == v.waits);
      PSLVERR = v.slverr;
      PRDATA  = v.prdata;
      @(negedge PCLK);
      chk($sformatf("v%0d rsp_valid early", idx), 64'(rsp_valid), 64'(0));
      chk($sformatf("v%0d m_write stable", idx), 64'(m_write), 64'(e_write));
      chk($sformatf("v%0d m_strb stable", idx), 64'(m_strb), 64'(e_strb));
      tick();
    end
    PENABLE = 1'b0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    @(negedge PCLK);
    chk($sformatf("v%0d rsp_valid", idx), 64'(rsp_valid), 64'(2'b01 << v.win));
    chk($sformatf("v%0d rsp_rdata", idx), 64'(rsp_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d rsp_err", idx), 64'(rsp_err), 64'(v.exp_err));
    tick();
    @(negedge PCLK);
    chk($sformatf("v%0d rsp_valid pulse", idx), 64'(rsp_valid), 64'(0));
    chk($sformatf("v%0d rsp_rdata hold", idx), 64'(rsp_rdata), 64'(v.exp_rdata));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed vectors; winners follow from last_grant=1 after reset.
    vecs[0] = '{valid: 2'b01, write: 2'b00, addr0: 32'h0010_0004, addr1: 32'h0,
                wdata0: 32'h0, wdata1: 32'h0, strb0: 4'h0, strb1: 4'h0,
                prot0: 3'h2, prot1: 3'h0, prdata: 32'hDEAD_BEEF, waits: 0,
                slverr: 1'b0, win: 0, exp_rdata: 32'hDEAD_BEEF, exp_err: 1'b0};
    vecs[1] = '{valid: 2'b11, write: 2'b10, addr0: 32'h0000_0100, addr1: 32'h2000_0008,
                wdata0: 32'h0, wdata1: 32'h1234_5678, strb0: 4'h0, strb1: 4'hF,
                prot0: 3'h0, prot1: 3'h5, prdata: 32'hFFFF_FFFF, waits: 3,
                slverr: 1'b1, win: 1, exp_rdata: 32'h0, exp_err: 1'b1};
    vecs[2] = '{valid: 2'b11, write: 2'b00, addr0: 32'h0000_0200, addr1: 32'h0000_0300,
                wdata0: 32'h0, wdata1: 32'h0, strb0: 4'h0, strb1: 4'h0,
                prot0: 3'h1, prot1: 3'h3, prdata: 32'hA5A5_0F0F, waits: 1,
                slverr: 1'b0, win: 0, exp_rdata: 32'hA5A5_0F0F, exp_err: 1'b0};
    vecs[3] = '{valid: 2'b01, write: 2'b01, addr0: 32'h0000_0400, addr1: 32'h0,
                wdata0: 32'hCAFE_F00D, wdata1: 32'h0, strb0: 4'h3, strb1: 4'h0,
                prot0: 3'h7, prot1: 3'h0, prdata: 32'h1111_1111, waits: 0,
                slverr: 1'b0, win: 0, exp_rdata: 32'h0, exp_err: 1'b0};
    vecs[4] = '{valid: 2'b10, write: 2'b00, addr0: 32'h0, addr1: 32'h0000_0500,
                wdata0: 32'h0, wdata1: 32'h0, strb0: 4'h0, strb1: 4'h0,
                prot0: 3'h0, prot1: 3'h4, prdata: 32'h0BAD_CAFE, waits: 2,
                slverr: 1'b1, win: 1, exp_rdata: 32'h0BAD_CAFE, exp_err: 1'b1};

    PRESETn = 1'b0;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_write = '0;
    req_strb = '0; req_prot = '0;
    PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    req_valid4 = '0; req_addr4 = '0; req_wdata4 = '0; req_write4 = '0;
    req_strb4 = '0; req_prot4 = '0;
    PENABLE4 = 1'b0; PREADY4 = 1'b0; PSLVERR4 = 1'b0; PRDATA4 = '0;
    tick();
    tick();
    @(negedge PCLK);
    chk("reset m_transfer", 64'(m_transfer), 64'(0));
    chk("reset m_addr", 64'(m_addr), 64'(0));
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset rsp_err", 64'(rsp_err), 64'(0));
    chk("reset req_ready", 64'(req_ready), 64'(0));
    PRESETn = 1'b1;
    tick();

    // Wrap-around on NREQ=4: last_grant=3 after reset, 4'b1001 -> 0 then 3.
    req_addr4 = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000, 32'h0000_0040};
    req_valid4 = 4'b1001;
    @(negedge PCLK);
    chk("wrap req_ready first", 64'(req_ready4), 64'(4'b0001));
    tick();
    req_valid4 = 4'b1000;
    @(negedge PCLK);
    chk("wrap m_addr first", 64'(m_addr4), 64'(32'h0000_0040));
    tick();
    tick();
    PENABLE4 = 1'b1; PREADY4 = 1'b1;
    tick();
    PENABLE4 = 1'b0; PREADY4 = 1'b0;
    @(negedge PCLK);
    chk("wrap rsp_valid first", 64'(rsp_valid4), 64'(4'b0001));
    chk("wrap req_ready second", 64'(req_ready4), 64'(4'b1000));
    tick();
    req_valid4 = 4'b0000;
    @(negedge PCLK);
    chk("wrap m_transfer second", 64'(m_transfer4), 64'(1));
    chk("wrap m_addr second", 64'(m_addr4), 64'(32'h3333_0000));
    tick();
    tick();
    PENABLE4 = 1'b1; PREADY4 = 1'b1;
    tick();
    PENABLE4 = 1'b0; PREADY4 = 1'b0;
    @(negedge PCLK);
    chk("wrap rsp_valid second", 64'(rsp_valid4), 64'(4'b1000));
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Mid-transfer reset: grant requester 1 (last_grant=1 -> search 0 first,
    // so present only requester 1), abort in WAIT.
    req_valid = 2'b10; req_write = 2'b00; req_addr = {32'h0000_0600, 32'h0};
    @(negedge PCLK);
    chk("abort req_ready", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    PENABLE = 1'b1; PREADY = 1'b0;
    #2;
    PRESETn = 1'b0;
    #1;
    chk("abort m_transfer", 64'(m_transfer), 64'(0));
    chk("abort m_addr", 64'(m_addr), 64'(0));
    chk("abort rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("abort rsp_err", 64'(rsp_err), 64'(0));
    PREADY = 1'b1;
    tick();
    @(negedge PCLK);
    chk("abort no rsp_valid", 64'(rsp_valid), 64'(0));
    PENABLE = 1'b0; PREADY = 1'b0;
    tick();
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("abort rsp_valid after release", 64'(rsp_valid), 64'(0));
    tick();

    // Contention: both held, zero-wait completions, 4-cycle spacing, 0,1,0,1.
    req_write = 2'b00;
    req_addr  = {32'h0000_1111, 32'h0000_0000};
    for (int c = 0; c <= 16; c++) begin
      logic [1:0]  e_ready, e_rsp;
      logic [31:0] e_addr;
      int          g;
      g = (c / 4) % 2;
      req_valid = (c < 16) ? 2'b11 : 2'b00;
      PENABLE   = (c % 4 == 3);
      PREADY    = (c % 4 == 3);
      e_ready = (c % 4 == 0 && c < 16) ? (2'b01 << g) : 2'b00;
      e_rsp   = (c % 4 == 0 && c > 0) ? (2'b01 << ((c / 4 - 1) % 2)) : 2'b00;
      e_addr  = (g == 0) ? 32'h0000_0000 : 32'h0000_1111;
      @(negedge PCLK);
      chk($sformatf("rr c%0d req_ready", c), 64'(req_ready), 64'(e_ready));
      chk($sformatf("rr c%0d rsp_valid", c), 64'(rsp_valid), 64'(e_rsp));
      chk($sformatf("rr c%0d m_transfer", c), 64'(m_transfer), 64'(c % 4 == 1 && c < 16));
      if (c % 4 == 1) chk($sformatf("rr c%0d m_addr", c), 64'(m_addr), 64'(e_addr));
      tick();
    end
    PENABLE = 1'b0; PREADY = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout with TIMEOUT=8: last_grant=1, so requester 0 wins.
    req_valid = 2'b01;
    @(negedge PCLK);
    chk("to req_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    for (int c = 3; c <= 9; c++) begin
      PENABLE = 1'b1; PREADY = 1'b0;
      @(negedge PCLK);
      chk($sformatf("to c%0d rsp_valid", c), 64'(rsp_valid), 64'(0));
      tick();
    end
    @(negedge PCLK);
    chk("to rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("to rsp_err", 64'(rsp_err), 64'(1));
    chk("to rsp_rdata", 64'(rsp_rdata), 64'(0));
    tick();
    @(negedge PCLK);
    chk("to rsp pulse", 64'(rsp_valid), 64'(0));
    tick();
    PREADY = 1'b1; PRDATA = 32'h5555_AAAA;
    tick();
    PENABLE = 1'b0; PREADY = 1'b0;
    req_valid = 2'b01;
    @(negedge PCLK);
    chk("to drain no rsp", 64'(rsp_valid), 64'(0));
    chk("to back to idle", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares the single APB master between up to NREQ on-chip requesters, such as the AXI slave read path, the AXI slave write path and the debug port. It latches one winning request and presents it to the APB master's addr/wdata/write_read/strb_input/PPROT_input/transfer inputs. It monitors PENABLE/PREADY/PSLVERR/PRDATA on the APB bus to detect completion, then returns read data and error status to the winner. Exactly one APB transfer is outstanding at a time.

## Interface
- ADDRSIZE, 32, address width
- DATASIZE, 32, data width; a multiple of 8
- NREQ, 2, requester count; legal range 2..4
- TIMEOUT, 255, wait-cycle limit; used only with the timeout feature
- PCLK  in  1  clock; all state is updated on the rising edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_addr  in  NREQ*ADDRSIZE  flattened; requester i occupies slice [i*ADDRSIZE +: ADDRSIZE]
- req_wdata  in  NREQ*DATASIZE  flattened write data
- req_write  in  NREQ  1 = write, 0 = read
- req_strb  in  NREQ*DATASIZE/8  flattened byte strobes
- req_prot  in  NREQ*3  flattened protection bits
- req_ready  out  NREQ  one-hot, one-cycle accept pulse
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATASIZE  read data; valid while rsp_valid is high
- rsp_err  out  1  error flag; valid while rsp_valid is high
- m_addr, m_wdata, m_write, m_strb, m_prot  out  ADDRSIZE/DATASIZE/1/DATASIZE/8/3  registered transfer fields to the APB master
- m_transfer  out  1  registered transfer request to the APB master
- PENABLE, PREADY, PSLVERR  in  1  APB bus monitor inputs
- PRDATA  in  DATASIZE  APB read data

## Operation
- States: IDLE, REQ, WAIT, plus DRAIN when the timeout feature is compiled in.
- IDLE, when any req_valid bit is set:
  - Pick the winner round-robin, searching from (last_grant+1) mod NREQ upward with wrap-around.
  - Latch the winner's fields into m_*.
  - Pulse req_ready[winner] in this cycle.
  - Set last_grant to the winner and go to REQ.
- IDLE, when no req_valid bit is set: remain in IDLE.
- REQ: m_transfer=1 for exactly this one cycle, then go to WAIT.
- WAIT: m_transfer=0 and m_* held stable.
  - On PENABLE && PREADY: capture rsp_rdata as PRDATA for a read or 0 for a write, and capture rsp_err as PSLVERR.
  - In the next cycle, rsp_valid[last_grant]=1 and the state is IDLE.
- m_* keep their last values until the next grant. rsp_rdata and rsp_err hold their values until the next completion.
- A requester must keep req_valid and its fields stable until it receives req_ready. It may deassert req_valid only after req_ready. A req_valid that drops before being granted is simply not served.
- Arbitration happens only in IDLE. Requests raised during REQ or WAIT are sampled at the next IDLE.

## Timing
- Reset values:
  - state = IDLE
  - last_grant = NREQ-1, so requester 0 wins first
  - m_* = 0, m_transfer = 0
  - req_ready = 0, rsp_valid = 0
  - rsp_rdata = 0, rsp_err = 0
  - timeout counter = 0
- Request flow: req_valid high in IDLE at cycle t gives req_ready at t and m_transfer at t+1. The APB master is in setup at t+2 and in access (PENABLE=1) from t+3.
- Completion flow: PENABLE && PREADY at cycle k gives rsp_valid at k+1. The state is IDLE at k+1, so the next grant is possible at k+1 and its m_transfer at k+2.
- Throughput: zero-wait-state back-to-back transfers take 4 cycles each.
- m_transfer is never high while the APB master is in access. This keeps the master returning to idle rather than to setup.
- Reset asserted mid-transfer aborts immediately to the reset values. No rsp_valid is issued for the aborted transfer.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT. It reaches TIMEOUT after TIMEOUT cycles without PENABLE && PREADY.
  - At that point: rsp_valid[last_grant]=1, rsp_err=1, rsp_rdata=0, then go to DRAIN.
  - DRAIN waits for PENABLE && PREADY with no further response, then goes to IDLE.
  - The counter clears on every entry to WAIT.
- APB_ARB_TIMEOUT_EN undefined: no counter and no DRAIN state. WAIT lasts indefinitely, and the TIMEOUT parameter is ignored.

## Test plan
- Single read: req_valid[0], addr 0x0010_0004, PRDATA=0xDEADBEEF with PREADY in the first access cycle -> req_ready[0] at t, m_transfer at t+1, rsp_valid[0] with rsp_rdata=0xDEADBEEF and rsp_err=0 at t+4.
- Contention: req_valid=2'b11 held continuously, NREQ=2 -> grants in order 0,1,0,1, each transfer 4 cycles apart.
- Write with 3 PREADY wait cycles and PSLVERR=1 -> m_write=1 and m_strb=0xF stable throughout, rsp_valid after the final access cycle, rsp_err=1, rsp_rdata=0.
- Mid-transfer reset: PRESETn low during WAIT -> all outputs 0 asynchronously, no rsp_valid; the first grant after reset goes to requester 0.
- Timeout (macro on, TIMEOUT=8): PREADY held low -> rsp_valid with rsp_err=1 after 8 WAIT cycles; a later PREADY produces no second response; state returns to IDLE.
- Wrap-around, NREQ=4: last_grant=3 with req_valid=4'b1001 -> requester 0 granted, then requester 3.
